draw_pair_fetch: RTL and testbench
==================================

// Module: draw_pair_fetch
// PURPOSE
//  Downstream of the 6656..6784 draw address-pair counter. Takes each (even, odd) address pair,
//  reads both words from a dual-port ROM (1-cycle read latency) and emits one packed pair per
//  handshake to the draw writer. Absorbs writer backpressure in a small FIFO.
// PARAMETERS
//  ADDR_W     14      address width of addr_a/addr_b and ROM ports
//  DATA_W     8       ROM word width; out_data is 2*DATA_W
//  FIFO_DEPTH 4       output FIFO entries, power of two, >= 2
//  END_ADDR   13568   first even address NOT fetched (6784*2); reaching it ends the frame
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  start      in   1         1-cycle pulse: begin frame (ignored unless IDLE or DONE)
//  addr_a     in   ADDR_W    even address of current pair (LSB 0)
//  addr_b     in   ADDR_W    odd address of current pair (LSB 1)
//  addr_step  out  1         pulse: pair consumed, upstream counter may advance
//  rom_addr_a out  ADDR_W    ROM port A address
//  rom_addr_b out  ADDR_W    ROM port B address
//  rom_rd     out  1         ROM read strobe; data valid on rom_q_* next cycle
//  rom_q_a    in   DATA_W    ROM port A data
//  rom_q_b    in   DATA_W    ROM port B data
//  out_valid  out  1         FIFO head valid
//  out_ready  in   1         consumer accepts when out_valid && out_ready
//  out_data   out  2*DATA_W  {rom_q_b, rom_q_a}
//  out_addr   out  ADDR_W    even address the head pair was read from
//  busy       out  1         high in RUN or DRAIN
//  done       out  1         1-cycle pulse on DRAIN->DONE
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, in-flight flag 0; all outputs 0.
//  FSM: IDLE -start-> RUN; RUN -(issue with addr_a==END_ADDR-2)-> DRAIN;
//       DRAIN -(no read in flight && FIFO empty)-> DONE (done pulse); DONE -start-> RUN.
//  Issue (RUN only): rom_rd=1 when (fifo_count + inflight) < FIFO_DEPTH; same cycle
//   rom_addr_* = addr_*, addr_step=1. Max one issue per cycle; full throughput 1 pair/clk.
//  Capture: cycle after rom_rd, {rom_q_b,rom_q_a} and registered addr push to FIFO; never
//   overflows (credit rule above). Push and pop in same cycle: count unchanged.
//  Output: out_* combinational from FIFO head; pop on out_valid && out_ready.
//  addr_a >= END_ADDR in RUN: no issue, go straight to DRAIN (counter already saturated).
//  start while RUN/DRAIN: ignored. reset mid-frame: FIFO flushed, in-flight read discarded.
//  ROM addresses wrap modulo 2^ADDR_W; no arithmetic on data words.
// CONFIGURATION
//  DRAW_PAIR_CHECK_EN defined: add output pair_err (1 bit, reset 0), sticky until reset/start;
//   set on any issue where addr_a[0]!=0 or addr_b!=addr_a+1. Fetch proceeds regardless.
//  Undefined: no pair_err port, no check logic.
// STRUCTURE
//  Package draw_pkg: ADDR_W/DATA_W defaults, END_ADDR, typedef enum {IDLE,RUN,DRAIN,DONE}
//   fetch_state_t, typedef struct {addr, data} pair_t.
//  Sub-module draw_pair_fifo: synchronous FIFO of pair_t, FIFO_DEPTH, push/pop/count/empty.
// TESTING
//  1 Reset then start, addr sweep 13312..13566 step 2, out_ready=1 -> 128 pairs, in order,
//    out_data matches ROM model, done pulse exactly once, busy low after.
//  2 out_ready=0 after start -> exactly FIFO_DEPTH rom_rd issues, then rom_rd=0, addr_step=0;
//    release out_ready -> stream resumes with no loss or duplicate.
//  3 out_ready toggling 1010.. -> push/pop same cycle keeps count stable; data order intact.
//  4 Start with addr_a=13568 -> no rom_rd, DRAIN->DONE, done pulse within 2 clocks.
//  5 reset asserted with 3 pairs in FIFO -> next clock out_valid=0, busy=0, state IDLE.
//  6 DRAW_PAIR_CHECK_EN: addr_b=addr_a+3 once -> pair_err=1 and held; clears on start.

Source files
------------

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types and defaults for the draw address-pair fetch path
package draw_pkg;

  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_END_ADDR   = 13568;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic [2*DEF_DATA_W-1:0] data;
  } pair_t;

endpackage

// File: rtl/draw_pair_fifo.sv
// rtl/draw_pair_fifo.sv - synchronous FIFO of fetched pairs with occupancy count
module draw_pair_fifo
  import draw_pkg::*;
#(
  parameter int  DEPTH  = DEF_FIFO_DEPTH,
  parameter type item_t = pair_t,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  item_t            push_item,
  input  logic             pop,
  output item_t            head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  item_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; contents are don't-care until the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_item;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; push+pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/draw_pair_fetch.sv
// rtl/draw_pair_fetch.sv - fetches (even, odd) ROM word pairs into an output FIFO; DRAW_PAIR_CHECK_EN adds pair_err
module draw_pair_fetch
  import draw_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int END_ADDR   = DEF_END_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  output logic                addr_step,
  output logic [ADDR_W-1:0]   rom_addr_a,
  output logic [ADDR_W-1:0]   rom_addr_b,
  output logic                rom_rd,
  input  logic [DATA_W-1:0]   rom_q_a,
  input  logic [DATA_W-1:0]   rom_q_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                busy,
  output logic                done
`ifdef DRAW_PAIR_CHECK_EN
  ,
  output logic                pair_err
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] data;
  } entry_t;

  fetch_state_t      state;
  logic              inflight;
  logic [ADDR_W-1:0] cap_addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  entry_t            fifo_head;
  entry_t            push_item;
  logic [CNT_W:0]    credit_used;
  logic              addr_in_range;
  logic              issue;
  logic              pop;
  logic              start_ok;

  // A read is only issued when the FIFO is guaranteed to have room for its data,
  // counting the read already travelling through the ROM.
  assign credit_used   = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
  assign addr_in_range = (addr_a < ADDR_W'(END_ADDR));
  assign issue         = (state == RUN) && addr_in_range &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign start_ok      = start && ((state == IDLE) || (state == DONE));

  assign rom_rd     = issue;
  assign addr_step  = issue;
  assign rom_addr_a = issue ? addr_a : '0;
  assign rom_addr_b = issue ? addr_b : '0;

  // Frame sequencing: run until the last pair is issued (or the counter is already
  // past the end), then wait for the pipeline and FIFO to empty before pulsing done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!addr_in_range) begin
            state <= DRAIN;
          end else if (issue && (addr_a == ADDR_W'(END_ADDR - 2))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM read pipeline: remember the even address so it can travel with the returned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      cap_addr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        cap_addr <= addr_a;
      end
    end
  end

  assign push_item = '{addr: cap_addr, data: {rom_q_b, rom_q_a}};
  assign pop       = out_valid && out_ready;

  draw_pair_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_item (push_item),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head.data;
  assign out_addr  = fifo_empty ? '0 : fifo_head.addr;
  assign busy      = (state == RUN) || (state == DRAIN);

`ifdef DRAW_PAIR_CHECK_EN
  // Sticky malformed-pair flag; cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_err <= 1'b0;
    end else if (start_ok) begin
      pair_err <= 1'b0;
    end else if (issue && (addr_a[0] || (addr_b != addr_a + ADDR_W'(1)))) begin
      pair_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_draw_pair_fetch.sv
// tb/tb_draw_pair_fetch.sv - scoreboard bench for draw_pair_fetch
module tb_draw_pair_fetch;

  localparam int END_A = 13568;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] addr_a = 14'd13312;
  logic [13:0] addr_b = 14'd13313;
  logic        addr_step;
  logic [13:0] rom_addr_a;
  logic [13:0] rom_addr_b;
  logic        rom_rd;
  logic [7:0]  rom_q_a = 8'd0;
  logic [7:0]  rom_q_b = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [13:0] out_addr;
  logic        busy;
  logic        done;
`ifdef DRAW_PAIR_CHECK_EN
  logic        pair_err;
`endif

  draw_pair_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_step  (addr_step),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_rd     (rom_rd),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
`ifdef DRAW_PAIR_CHECK_EN
    ,
    .pair_err   (pair_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   popped = 0;
  logic ready_toggle = 1'b0;

  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b10};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted output must match the oldest expected pair.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {18'd0, out_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_addr", {18'd0, out_addr}, {18'd0, e.addr});
        chk("out_data", {16'd0, out_data}, {16'd0, e.data});
        popped++;
      end
    end
  end

  // One clock of stimulus: observe at negedge, update ROM and counter models after posedge.
  task automatic tick();
    logic       s_rd;
    logic       s_step;
    logic [13:0] s_aa;
    logic [13:0] s_ab;
    exp_t       e;
    @(negedge clk);
    s_rd   = rom_rd;
    s_step = addr_step;
    s_aa   = rom_addr_a;
    s_ab   = rom_addr_b;
    if (done === 1'b1) done_cnt++;
    if (s_rd === 1'b1) begin
      chk("rom_addr_a", {18'd0, s_aa}, {18'd0, addr_a});
      chk("rom_addr_b", {18'd0, s_ab}, {18'd0, addr_b});
      e.addr = addr_a;
      e.data = {rom_fn(addr_b), rom_fn(addr_a)};
      sb.push_back(e);
      rd_cnt++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ready_toggle) out_ready = ~out_ready;
    if (s_rd === 1'b1) begin
      rom_q_a = rom_fn(s_aa);
      rom_q_b = rom_fn(s_ab);
    end
    if (s_step === 1'b1 && addr_a < 14'(END_A)) begin
      addr_a = addr_a + 14'd2;
      addr_b = addr_a + 14'd1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int p0;
    int d0;

    // Reset state
    ticks(3);
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_addr_step", 32'(addr_step), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // 1: full sweep with consumer always ready
    out_ready = 1'b1;
    r0 = rd_cnt; p0 = popped; d0 = done_cnt;
    start = 1'b1;
    wait_done(400);
    ticks(3);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_issues", 32'(rd_cnt - r0), 32'd128);
    chk("t1_pairs", 32'(popped - p0), 32'd128);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: consumer stalled, FIFO credit limits issues
    addr_a = 14'd13312; addr_b = 14'd13313;
    out_ready = 1'b0;
    r0 = rd_cnt; p0 = popped;
    start = 1'b1;
    ticks(20);
    chk("t2_stall_issues", 32'(rd_cnt - r0), 32'd4);
    chk("t2_stall_rom_rd", 32'(rom_rd), 32'd0);
    chk("t2_stall_step", 32'(addr_step), 32'd0);
    chk("t2_stall_valid", 32'(out_valid), 32'd1);
    chk("t2_stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done(400);
    ticks(2);
    chk("t2_pairs", 32'(popped - p0), 32'd128);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: consumer ready toggling every cycle
    addr_a = 14'd13312; addr_b = 14'd13313;
    r0 = rd_cnt; p0 = popped;
    out_ready = 1'b1;
    ready_toggle = 1'b1;
    start = 1'b1;
    wait_done(800);
    ready_toggle = 1'b0;
    out_ready = 1'b1;
    ticks(2);
    chk("t3_issues", 32'(rd_cnt - r0), 32'd128);
    chk("t3_pairs", 32'(popped - p0), 32'd128);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: counter already saturated at frame start
    addr_a = 14'(END_A); addr_b = 14'(END_A + 1);
    r0 = rd_cnt; d0 = done_cnt;
    start = 1'b1;
    wait_done(4);
    chk("t4_no_issue", 32'(rd_cnt - r0), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);

    // 5: reset with three pairs waiting in the FIFO
    addr_a = 14'd13562; addr_b = 14'd13563;
    out_ready = 1'b0;
    r0 = rd_cnt;
    start = 1'b1;
    ticks(10);
    chk("t5_issues", 32'(rd_cnt - r0), 32'd3);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_post_valid", 32'(out_valid), 32'd0);
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    ticks(2);
    chk("t5_idle_no_rd", 32'(rom_rd), 32'd0);

`ifdef DRAW_PAIR_CHECK_EN
    // 6: one malformed pair sets the sticky error; the next start clears it
    addr_a = 14'd13560; addr_b = 14'd13563;
    chk("t6_err_clear", 32'(pair_err), 32'd0);
    start = 1'b1;
    wait_done(100);
    chk("t6_err_set", 32'(pair_err), 32'd1);
    ticks(2);
    chk("t6_err_held", 32'(pair_err), 32'd1);
    start = 1'b1;
    tick();
    chk("t6_err_cleared", 32'(pair_err), 32'd0);
    wait_done(6);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
